// File: rtl/vend_panel_arbiter.sv
// Two-panel front end for a single shared vending controller core.
// One panel at a time owns the core. Ownership is won by a quarter in IDLE,
// kept while the customer has credit, and released after a completion with
// no credit left or after IDLE_TIMEOUT idle cycles with no credit.
//
// Handshake: vend_valid is a one-cycle pulse with no back-pressure. vend_code
// and vend_owner are only meaningful while vend_valid=1 and are 0 otherwise.
//
// Timeout timing: the counter counts consecutive idle OWN cycles. The
// IDLE_TIMEOUT-th idle cycle in a row triggers the release, so the grant is
// seen low on the cycle after it.
module vend_panel_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rnot,
  input  logic       quarter_a,
  input  logic       select1_a,
  input  logic       select2_a,
  input  logic       quarter_b,
  input  logic       select1_b,
  input  logic       select2_b,
  output logic       core_quarter_in,
  output logic       core_select1,
  output logic       core_select2,
  input  logic       core_product1,
  input  logic       core_product2,
  input  logic       core_quarter_out,
  input  logic [1:0] core_i,
  output logic       grant_a,
  output logic       grant_b,
  output logic       vend_valid,
  output logic [1:0] vend_code,
  output logic       vend_owner,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(IDLE_TIMEOUT - 1);

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic [3:0] idle_cnt;

  logic       own_quarter;
  logic       own_select1;
  logic       own_select2;
  logic       own_strobe;
  logic       done;
  logic [1:0] done_code;
  logic       idle_tick;
  logic       timeout;
  logic       pick_b;

  // Owner strobe selection, completion decode and timeout detection.
  always_comb begin
    own_quarter = owner ? quarter_b : quarter_a;
    own_select1 = owner ? select1_b : select1_a;
    own_select2 = owner ? select2_b : select2_a;
    own_strobe  = own_quarter | own_select1 | own_select2;
    done        = core_product1 | core_product2 | core_quarter_out;
    // Refund beats product2 beats product1.
    if (core_quarter_out)   done_code = 2'b11;
    else if (core_product2) done_code = 2'b10;
    else                    done_code = 2'b01;
    idle_tick   = (core_i == 2'b00) && !own_strobe;
    timeout     = idle_tick && (idle_cnt == TO_LAST);
    // A tie goes to the panel that did not own last; otherwise the lone quarter wins.
    pick_b      = (quarter_a && quarter_b) ? ~last_owner : quarter_b;
  end

  assign state_dbg = state;

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rnot) begin
      state           <= ST_IDLE;
      owner           <= 1'b0;
      last_owner      <= 1'b1;
      idle_cnt        <= 4'd0;
      grant_a         <= 1'b0;
      grant_b         <= 1'b0;
      core_quarter_in <= 1'b0;
      core_select1    <= 1'b0;
      core_select2    <= 1'b0;
      vend_valid      <= 1'b0;
      vend_code       <= 2'b00;
      vend_owner      <= 1'b0;
    end else begin
      core_quarter_in <= 1'b0;
      core_select1    <= 1'b0;
      core_select2    <= 1'b0;
      vend_valid      <= 1'b0;
      vend_code       <= 2'b00;
      vend_owner      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (quarter_a || quarter_b) begin
            state           <= ST_OWN;
            owner           <= pick_b;
            grant_a         <= ~pick_b;
            grant_b         <= pick_b;
            idle_cnt        <= 4'd0;
            // Replay the winning quarter into the core.
            core_quarter_in <= 1'b1;
          end
        end
        ST_OWN: begin
          if (done) begin
            state      <= ST_DRAIN;
            idle_cnt   <= 4'd0;
            vend_valid <= 1'b1;
            vend_code  <= done_code;
            vend_owner <= owner;
          end else if (timeout) begin
            state      <= ST_IDLE;
            last_owner <= owner;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            idle_cnt   <= 4'd0;
          end else begin
            core_quarter_in <= own_quarter;
            core_select1    <= own_select1;
            core_select2    <= own_select2;
            idle_cnt        <= idle_tick ? idle_cnt + 4'd1 : 4'd0;
          end
        end
        ST_DRAIN: begin
          idle_cnt <= 4'd0;
          if (core_i == 2'b00) begin
            state      <= ST_IDLE;
            last_owner <= owner;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
          end else begin
            state <= ST_OWN;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter, built with IDLE_TIMEOUT=3.
// Cycle n is the interval after the n-th rising edge; inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_vend_panel_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic       clk = 1'b0;
  logic       rnot;
  logic       quarter_a, select1_a, select2_a;
  logic       quarter_b, select1_b, select2_b;
  logic       core_quarter_in, core_select1, core_select2;
  logic       core_product1, core_product2, core_quarter_out;
  logic [1:0] core_i;
  logic       grant_a, grant_b;
  logic       vend_valid;
  logic [1:0] vend_code;
  logic       vend_owner;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  vend_panel_arbiter #(.IDLE_TIMEOUT(3)) dut (
    .clk(clk), .rnot(rnot),
    .quarter_a(quarter_a), .select1_a(select1_a), .select2_a(select2_a),
    .quarter_b(quarter_b), .select1_b(select1_b), .select2_b(select2_b),
    .core_quarter_in(core_quarter_in), .core_select1(core_select1), .core_select2(core_select2),
    .core_product1(core_product1), .core_product2(core_product2), .core_quarter_out(core_quarter_out),
    .core_i(core_i),
    .grant_a(grant_a), .grant_b(grant_b),
    .vend_valid(vend_valid), .vend_code(vend_code), .vend_owner(vend_owner),
    .state_dbg(state_dbg)
  );

  // Grants must never both be high, checked every cycle after reset release.
  always @(negedge clk) begin
    if (rnot === 1'b1) begin
      n_checks++;
      if (grant_a && grant_b) $display("FAIL grant_exclusive: grant_a=%b grant_b=%b want not both 1", grant_a, grant_b);
      else n_pass++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    quarter_a = 0; select1_a = 0; select2_a = 0;
    quarter_b = 0; select1_b = 0; select2_b = 0;
    core_product1 = 0; core_product2 = 0; core_quarter_out = 0;
    core_i = 2'b00;
  endtask

  task automatic test_reset();
    rnot = 0;
    clear_inputs();
    quarter_a = 1; select1_a = 1; core_product1 = 1;
    step(); step();
    n_checks++; if (state_dbg !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); else n_pass++;
    n_checks++; if ({grant_a, grant_b} !== 2'b00) $display("FAIL reset_grants: got %b want 00", {grant_a, grant_b}); else n_pass++;
    n_checks++; if ({vend_valid, vend_code, vend_owner} !== 4'b0000) $display("FAIL reset_vend: got %b want 0000", {vend_valid, vend_code, vend_owner}); else n_pass++;
    n_checks++; if ({core_quarter_in, core_select1, core_select2} !== 3'b000) $display("FAIL reset_core: got %b want 000", {core_quarter_in, core_select1, core_select2}); else n_pass++;
    clear_inputs();
    rnot = 1;
    // Selects in IDLE are ignored.
    select1_a = 1; select2_b = 1;
    step();
    n_checks++; if ({core_select1, core_select2, state_dbg} !== {2'b00, S_IDLE}) $display("FAIL idle_select_ignored: got %b want %b", {core_select1, core_select2, state_dbg}, {2'b00, S_IDLE}); else n_pass++;
    clear_inputs();
  endtask

  // Tie after reset goes to A, refund releases, next tie goes to B; then B lockout and priority/drain.
  task automatic test_tie_lockout_priority();
    quarter_a = 1; quarter_b = 1;
    step();
    n_checks++; if ({grant_a, grant_b} !== 2'b10) $display("FAIL tie1_grant: got %b want 10", {grant_a, grant_b}); else n_pass++;
    n_checks++; if (core_quarter_in !== 1'b1) $display("FAIL tie1_replay: got %b want 1", core_quarter_in); else n_pass++;
    clear_inputs();
    core_quarter_out = 1;
    step();
    n_checks++; if ({vend_valid, vend_code, vend_owner} !== 4'b1110) $display("FAIL tie1_refund: got %b want 1110", {vend_valid, vend_code, vend_owner}); else n_pass++;
    clear_inputs();
    step();
    n_checks++; if ({grant_a, grant_b, state_dbg} !== {2'b00, S_IDLE}) $display("FAIL tie1_release: got %b want %b", {grant_a, grant_b, state_dbg}, {2'b00, S_IDLE}); else n_pass++;
    quarter_a = 1; quarter_b = 1;
    step();
    n_checks++; if ({grant_a, grant_b} !== 2'b01) $display("FAIL tie2_grant: got %b want 01", {grant_a, grant_b}); else n_pass++;
    clear_inputs();
    core_i = 2'b01;
    select1_a = 1; quarter_a = 1;
    step();
    n_checks++; if ({core_select1, core_quarter_in, grant_a} !== 3'b000) $display("FAIL lockout_a: got %b want 000", {core_select1, core_quarter_in, grant_a}); else n_pass++;
    select1_a = 0; quarter_a = 0;
    select2_b = 1;
    step();
    n_checks++; if ({core_select1, core_select2} !== 2'b01) $display("FAIL owner_b_select2: got %b want 01", {core_select1, core_select2}); else n_pass++;
    select2_b = 0;
    core_product2 = 1; core_quarter_out = 1;
    step();
    n_checks++; if ({vend_valid, vend_code, vend_owner} !== 4'b1111) $display("FAIL priority_refund: got %b want 1111", {vend_valid, vend_code, vend_owner}); else n_pass++;
    n_checks++; if (state_dbg !== S_DRAIN) $display("FAIL priority_drain_state: got %0d want %0d", state_dbg, S_DRAIN); else n_pass++;
    core_product2 = 0; core_quarter_out = 0;
    select1_b = 1;
    step();
    n_checks++; if ({state_dbg, grant_b, vend_valid} !== {S_OWN, 2'b10}) $display("FAIL drain_return_own: got %b want %b", {state_dbg, grant_b, vend_valid}, {S_OWN, 2'b10}); else n_pass++;
    n_checks++; if (core_select1 !== 1'b0) $display("FAIL drain_drop_strobe: got %b want 0", core_select1); else n_pass++;
    select1_b = 0;
    core_i = 2'b00; core_product1 = 1;
    step();
    n_checks++; if ({vend_valid, vend_code, vend_owner} !== 4'b1011) $display("FAIL b_product1: got %b want 1011", {vend_valid, vend_code, vend_owner}); else n_pass++;
    clear_inputs();
    step();
    n_checks++; if ({grant_b, state_dbg} !== {1'b0, S_IDLE}) $display("FAIL b_release: got %b want %b", {grant_b, state_dbg}, {1'b0, S_IDLE}); else n_pass++;
  endtask

  // Panel A single transaction: quarter at 0, select at 1, product1 at 5.
  task automatic test_single_a();
    quarter_a = 1;
    step();
    n_checks++; if ({grant_a, grant_b, core_quarter_in} !== 3'b101) $display("FAIL single_grant: got %b want 101", {grant_a, grant_b, core_quarter_in}); else n_pass++;
    quarter_a = 0; core_i = 2'b01; select1_a = 1; select2_b = 1;
    step();
    n_checks++; if ({core_quarter_in, core_select1, core_select2} !== 3'b010) $display("FAIL single_select1: got %b want 010", {core_quarter_in, core_select1, core_select2}); else n_pass++;
    select1_a = 0; select2_b = 0;
    step(); step(); step();
    n_checks++; if ({vend_valid, grant_a} !== 2'b01) $display("FAIL single_hold: got %b want 01", {vend_valid, grant_a}); else n_pass++;
    core_i = 2'b00; core_product1 = 1;
    step();
    n_checks++; if ({vend_valid, vend_code, vend_owner} !== 4'b1010) $display("FAIL single_vend: got %b want 1010", {vend_valid, vend_code, vend_owner}); else n_pass++;
    core_product1 = 0;
    step();
    n_checks++; if ({grant_a, vend_valid, vend_code} !== 4'b0000) $display("FAIL single_release: got %b want 0000", {grant_a, vend_valid, vend_code}); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_timeout();
    // Plain timeout: idle cycles 1,2,3 in OWN, grant low at cycle 4.
    quarter_a = 1;
    step();
    quarter_a = 0;
    step(); step();
    n_checks++; if (grant_a !== 1'b1) $display("FAIL timeout_hold_c3: got %b want 1", grant_a); else n_pass++;
    step();
    n_checks++; if ({grant_a, vend_valid, state_dbg} !== {2'b00, S_IDLE}) $display("FAIL timeout_release: got %b want %b", {grant_a, vend_valid, state_dbg}, {2'b00, S_IDLE}); else n_pass++;
    // Owner strobe at cycle 3 restarts the count: release moves to cycle 7.
    quarter_a = 1;
    step();
    quarter_a = 0;
    step(); step();
    select2_a = 1;
    step();
    n_checks++; if ({grant_a, core_select2} !== 2'b11) $display("FAIL timeout_strobe_clear: got %b want 11", {grant_a, core_select2}); else n_pass++;
    select2_a = 0;
    step(); step();
    n_checks++; if (grant_a !== 1'b1) $display("FAIL timeout_hold_c6: got %b want 1", grant_a); else n_pass++;
    step();
    n_checks++; if ({grant_a, vend_valid} !== 2'b00) $display("FAIL timeout_release_c7: got %b want 00", {grant_a, vend_valid}); else n_pass++;
    // Completion on the timeout cycle wins.
    quarter_a = 1;
    step();
    quarter_a = 0;
    step(); step();
    core_product1 = 1;
    step();
    n_checks++; if ({state_dbg, vend_valid, vend_code} !== {S_DRAIN, 3'b101}) $display("FAIL done_beats_timeout: got %b want %b", {state_dbg, vend_valid, vend_code}, {S_DRAIN, 3'b101}); else n_pass++;
    clear_inputs();
    step();
    n_checks++; if (state_dbg !== S_IDLE) $display("FAIL done_timeout_idle: got %0d want %0d", state_dbg, S_IDLE); else n_pass++;
  endtask

  // Credit holds ownership for 20 idle cycles, then reset mid-transaction aborts it.
  task automatic test_credit_and_reset();
    quarter_a = 1;
    step();
    quarter_a = 0; core_i = 2'b01;
    for (int i = 0; i < 20; i++) step();
    n_checks++; if ({grant_a, state_dbg} !== {1'b1, S_OWN}) $display("FAIL credit_hold: got %b want %b", {grant_a, state_dbg}, {1'b1, S_OWN}); else n_pass++;
    rnot = 0; core_product1 = 1; select1_a = 1;
    step();
    n_checks++; if ({grant_a, grant_b, vend_valid, vend_code, vend_owner, core_quarter_in, core_select1, core_select2} !== 9'b0) $display("FAIL midreset_outputs: got %b want 000000000", {grant_a, grant_b, vend_valid, vend_code, vend_owner, core_quarter_in, core_select1, core_select2}); else n_pass++;
    n_checks++; if (state_dbg !== S_IDLE) $display("FAIL midreset_state: got %0d want %0d", state_dbg, S_IDLE); else n_pass++;
    clear_inputs();
    rnot = 1;
    quarter_a = 1; quarter_b = 1;
    step();
    n_checks++; if ({grant_a, grant_b} !== 2'b10) $display("FAIL midreset_tie: got %b want 10", {grant_a, grant_b}); else n_pass++;
    clear_inputs();
    step(); step(); step();
  endtask

  initial begin
    rnot = 0;
    clear_inputs();
    test_reset();
    test_tie_lockout_priority();
    test_single_a();
    test_timeout();
    test_credit_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
